// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: register-file write request and
// the starvation FSM state.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_WIDTH = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic {
        NORMAL = 1'b0,
        STALL  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests. Exposes per-slot valid/rd so
// the parent can build a pending-destination mask without reading payloads.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 push,
    input  logic                                 pop,
    input  wb_req_t                              push_req,
    output wb_req_t                              head,
    output logic                                 full,
    output logic                                 empty,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic [DEPTH-1:0]                     entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_rd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
            entry_rd[i]    = mem[i].rd;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: arbitrates the in-order ALU stream against buffered LSU
// results onto the register-file write port, stalling the ALU on starvation.
module wb_arbiter
    import wb_pkg::REG_ADDR_W, wb_pkg::wb_req_t, wb_pkg::wb_state_e,
           wb_pkg::NORMAL, wb_pkg::STALL;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   alu_valid_i,
    input  logic [REG_ADDR_W-1:0]  alu_rd_i,
    input  logic [DATA_WIDTH-1:0]  alu_data_i,
    input  logic                   lsu_valid_i,
    output logic                   lsu_ready_o,
    input  logic [REG_ADDR_W-1:0]  lsu_rd_i,
    input  logic [DATA_WIDTH-1:0]  lsu_data_i,
    output logic                   we_o,
    output logic [31:0]            w_addr_o,
    output logic [DATA_WIDTH-1:0]  w_data_o,
    output logic                   stall_o,
    output logic [31:0]            busy_mask_o
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    wb_req_t                             head;
    wb_req_t                             lsu_req;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic [CNT_W-1:0]                    fifo_count;
    logic [CNT_W-1:0]                    count_next;
    logic [FIFO_DEPTH-1:0]               entry_valid;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
    logic                                push;
    logic                                pop;
    logic                                lsu_acc;
    logic                                alu_sel;
    logic                                head_sel;
    logic                                head_drop;
    logic                                fifo_drains;
    logic                                byp_sel;
    logic                                we_next;
    logic [REG_ADDR_W-1:0]               sel_rd;
    logic [DATA_WIDTH-1:0]               sel_data;
    logic [WAIT_W-1:0]                   wait_cnt;
    logic [WAIT_W-1:0]                   wait_next;
    wb_state_e                           state;

    assign lsu_ready_o = !fifo_full;
    assign lsu_acc     = lsu_valid_i && !fifo_full;
    assign lsu_req     = '{rd: lsu_rd_i, data: lsu_data_i};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push        (push),
        .pop         (pop),
        .push_req    (lsu_req),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    // An x0 head leaves without a write slot, so a lone x0 entry lets the
    // LSU bypass path act as if the FIFO were already empty.
    always_comb begin
        alu_sel     = alu_valid_i && (alu_rd_i != '0) && !stall_o;
        head_drop   = !fifo_empty && (head.rd == '0);
        head_sel    = !fifo_empty && !head_drop && !alu_sel;
        pop         = head_sel || head_drop;
        fifo_drains = fifo_empty || ((fifo_count == CNT_W'(1)) && head_drop);
        byp_sel     = lsu_acc && fifo_drains && !alu_sel;
        push        = lsu_acc && !byp_sel;
        we_next     = alu_sel || head_sel || (byp_sel && (lsu_rd_i != '0));
        count_next  = fifo_count + CNT_W'(push) - CNT_W'(pop);

        sel_rd   = lsu_rd_i;
        sel_data = lsu_data_i;
        if (alu_sel) begin
            sel_rd   = alu_rd_i;
            sel_data = alu_data_i;
        end else if (head_sel) begin
            sel_rd   = head.rd;
            sel_data = head.data;
        end

        wait_next = wait_cnt;
        if (fifo_empty || pop)                  wait_next = '0;
        else if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_next = wait_cnt + 1'b1;
    end

    always_comb begin
        busy_mask_o = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) busy_mask_o[entry_rd[i]] = 1'b1;
        end
        busy_mask_o[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= NORMAL;
            stall_o  <= 1'b0;
            wait_cnt <= '0;
            we_o     <= 1'b0;
            w_addr_o <= '0;
            w_data_o <= '0;
        end else begin
            wait_cnt <= wait_next;
            we_o     <= we_next;
            if (we_next) begin
                w_addr_o <= {{(32-REG_ADDR_W){1'b0}}, sel_rd};
                w_data_o <= sel_data;
            end
            case (state)
                NORMAL: begin
                    if (wait_next == WAIT_W'(MAX_WAIT)) begin
                        state   <= STALL;
                        stall_o <= 1'b1;
                    end
                end
                STALL: begin
                    if (count_next == '0) begin
                        state   <= NORMAL;
                        stall_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= NORMAL;
                    stall_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
